// File: rtl/uart_ddr_pkg.sv
// Shared constants and helpers for the UART-to-DDR write path.
package uart_ddr_pkg;

  localparam int unsigned BYTE_W         = 8;
  localparam int unsigned FIFO_W_DEFAULT = 32;

  // Number of byte lanes in a word of the given bit width.
  function automatic int unsigned lanes_of(input int unsigned width);
    return width / BYTE_W;
  endfunction

endpackage

// File: rtl/fifo_wr_packer_if.sv
// Byte-in / FIFO-write-out bundle of the write-domain packer.
// master drives bytes, flush and full; slave is the packer.
interface fifo_wr_packer_if
  import uart_ddr_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = FIFO_W_DEFAULT
) ();

  localparam int unsigned NB = lanes_of(DATA_WIDTH);

  logic                  in_valid;
  logic [BYTE_W-1:0]     in_data;
  logic                  in_ready;
  logic                  flush;
  logic                  full;
  logic                  w_en;
  logic [DATA_WIDTH-1:0] wdata;
  logic [NB-1:0]         wstrb;

  modport master (
    output in_valid, in_data, flush, full,
    input  in_ready, w_en, wdata, wstrb
  );

  modport slave (
    input  in_valid, in_data, flush, full,
    output in_ready, w_en, wdata, wstrb
  );

endinterface

// File: rtl/fifo_wr_packer_timeout.sv
// Idle counter for the packer: counts while en is high, clears when en is low,
// and pulses for one cycle every TIMEOUT_CYCLES enabled cycles.
module packer_timeout #(
  parameter int unsigned TIMEOUT_CYCLES = 1024
) (
  input  logic wclk,
  input  logic wrst,
  input  logic en,
  output logic pulse
);

  localparam int unsigned CW = $clog2(TIMEOUT_CYCLES);

  logic [CW-1:0] cnt_q, cnt_d;

  assign pulse = en && (cnt_q == CW'(TIMEOUT_CYCLES - 1));

  always_comb begin
    cnt_d = cnt_q;
    if (!en || pulse) begin
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  always_ff @(posedge wclk or negedge wrst) begin
    if (!wrst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/fifo_wr_packer.sv
// Packs UART RX bytes little-endian into FIFO words with lane strobes.
// Optional idle-timeout partial flush is enabled by defining PACKER_TIMEOUT_EN.
module fifo_wr_packer
  import uart_ddr_pkg::*;
#(
  parameter int unsigned DATA_WIDTH     = FIFO_W_DEFAULT,
  parameter int unsigned TIMEOUT_CYCLES = 1024
) (
  input  logic            wclk,
  input  logic            wrst,
  fifo_wr_packer_if.slave bus,
  output logic [15:0]     wr_words
);

  localparam int unsigned NB = lanes_of(DATA_WIDTH);
  localparam int unsigned LW = $clog2(NB);
  localparam int unsigned AW = (NB - 1) * BYTE_W;

  logic [LW-1:0]         lane_q, lane_d;
  logic [AW-1:0]         asm_q, asm_d;
  logic [DATA_WIDTH-1:0] hold_data_q, hold_data_d;
  logic [NB-1:0]         hold_strb_q, hold_strb_d;
  logic                  hold_valid_q, hold_valid_d;
  logic                  flush_pend_q, flush_pend_d;
  logic [15:0]           wr_words_q;

  logic          w_en;
  logic          hold_free;
  logic          last_lane;
  logic          accept;
  logic          tmo_pulse;
  logic          flush_req;
  logic [NB-1:0] fill_mask;

  assign w_en      = hold_valid_q && !bus.full;
  assign hold_free = !hold_valid_q || w_en;
  assign last_lane = (lane_q == LW'(NB - 1));
  assign accept    = bus.in_valid && bus.in_ready;
  assign flush_req = bus.flush || tmo_pulse;

  assign bus.in_ready = !last_lane || hold_free;
  assign bus.w_en     = w_en;
  assign bus.wdata    = hold_data_q;
  assign bus.wstrb    = hold_strb_q;
  assign wr_words     = wr_words_q;

`ifdef PACKER_TIMEOUT_EN
  logic tmo_en;
  assign tmo_en = (lane_q != '0) && !accept;

  packer_timeout #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timeout (
    .wclk (wclk),
    .wrst (wrst),
    .en   (tmo_en),
    .pulse(tmo_pulse)
  );
`else
  logic unused_timeout_cfg;
  assign unused_timeout_cfg = (TIMEOUT_CYCLES != 0);
  assign tmo_pulse          = 1'b0;
`endif

  // Strobe for a partial word: one bit per lane already filled.
  always_comb begin
    fill_mask = '0;
    for (int unsigned k = 0; k < NB; k++) begin
      fill_mask[k] = (LW'(k) < lane_q);
    end
  end

  always_comb begin
    lane_d       = lane_q;
    asm_d        = asm_q;
    hold_data_d  = hold_data_q;
    hold_strb_d  = hold_strb_q;
    hold_valid_d = hold_valid_q;
    flush_pend_d = flush_pend_q || flush_req;

    if (w_en) begin
      hold_valid_d = 1'b0;
      hold_data_d  = '0;
      hold_strb_d  = '0;
    end

    if (accept) begin
      if (last_lane) begin
        hold_data_d  = {bus.in_data, asm_q};
        hold_strb_d  = '1;
        hold_valid_d = 1'b1;
        lane_d       = '0;
        asm_d        = '0;
        // Word is complete, so a coincident flush has nothing left to push.
        flush_pend_d = 1'b0;
      end else begin
        for (int unsigned k = 0; k < NB - 1; k++) begin
          if (lane_q == LW'(k)) begin
            asm_d[k*BYTE_W +: BYTE_W] = bus.in_data;
          end
        end
        lane_d = lane_q + LW'(1);
      end
    end else if (flush_pend_q) begin
      if (lane_q == '0) begin
        flush_pend_d = flush_req;
      end else if (hold_free) begin
        hold_data_d  = {{BYTE_W{1'b0}}, asm_q};
        hold_strb_d  = fill_mask;
        hold_valid_d = 1'b1;
        lane_d       = '0;
        asm_d        = '0;
        flush_pend_d = flush_req;
      end
    end
  end

  always_ff @(posedge wclk or negedge wrst) begin
    if (!wrst) begin
      lane_q       <= '0;
      asm_q        <= '0;
      hold_data_q  <= '0;
      hold_strb_q  <= '0;
      hold_valid_q <= 1'b0;
      flush_pend_q <= 1'b0;
      wr_words_q   <= '0;
    end else begin
      lane_q       <= lane_d;
      asm_q        <= asm_d;
      hold_data_q  <= hold_data_d;
      hold_strb_q  <= hold_strb_d;
      hold_valid_q <= hold_valid_d;
      flush_pend_q <= flush_pend_d;
      if (w_en) begin
        wr_words_q <= wr_words_q + 16'd1;
      end
    end
  end

endmodule
